argmax_pipe: RTL and testbench

//   Parametrised, fully pipelined argmax over N_CLASSES class scores.

---
 rtl/argmax_pipe.sv | 130 +++++++++++++
 tb/tb_argmax_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_pipe.sv
// Pipelined argmax over N_CLASSES scores: binary reduction tree, one register
// rank per level, lowest index wins on equal values, tie flag when the max repeats.
module argmax_pipe #(
    parameter int  N_CLASSES = 10,
    parameter int  W         = 16,
    parameter bit  SIGNED    = 1'b0,
    localparam int IDX_W     = $clog2(N_CLASSES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_CLASSES*W-1:0] in_scores,
    output logic                   out_valid,
    output logic [IDX_W-1:0]       out_index,
    output logic [W-1:0]           out_value,
    output logic                   out_tie
);
    localparam int LEVELS = IDX_W;
    localparam int NP     = 1 << LEVELS;

    function automatic logic beats(input logic [W-1:0] b, input logic [W-1:0] a);
        if (SIGNED) beats = $signed(b) > $signed(a);
        else        beats = b > a;
    endfunction

    // Level 0 is the (padded) leaf row; level LEVELS is the combinational root
    // that feeds the output registers. Levels in between are register ranks.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int NN = NP >> l;
        logic [NN-1:0]            vld;
        logic [NN-1:0][W-1:0]     val;
        logic [NN-1:0][IDX_W-1:0] idx;
        logic [NN-1:0]            tie;

        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < NP; k++) begin : g_k
                if (k < N_CLASSES) begin : g_real
                    assign vld[k] = 1'b1;
                    assign val[k] = in_scores[k*W +: W];
                end else begin : g_pad
                    assign vld[k] = 1'b0;
                    assign val[k] = '0;
                end
                assign idx[k] = IDX_W'(k);
                assign tie[k] = 1'b0;
            end
        end else begin : g_node
            localparam int NC = 2 * NN;
            logic [NC-1:0]            c_vld;
            logic [NC-1:0][W-1:0]     c_val;
            logic [NC-1:0][IDX_W-1:0] c_idx;
            logic [NC-1:0]            c_tie;
            logic [NN-1:0]            n_vld;
            logic [NN-1:0][W-1:0]     n_val;
            logic [NN-1:0][IDX_W-1:0] n_idx;
            logic [NN-1:0]            n_tie;
            logic [NN-1:0]            b_win;

            assign c_vld = g_lvl[l-1].vld;
            assign c_val = g_lvl[l-1].val;
            assign c_idx = g_lvl[l-1].idx;
            assign c_tie = g_lvl[l-1].tie;

            always_comb begin
                b_win = '0;
                n_vld = '0;
                n_val = '0;
                n_idx = '0;
                n_tie = '0;
                for (int j = 0; j < NN; j++) begin
                    b_win[j] = c_vld[2*j+1] &
                               (~c_vld[2*j] | beats(c_val[2*j+1], c_val[2*j]));
                    n_vld[j] = c_vld[2*j] | c_vld[2*j+1];
                    n_val[j] = b_win[j] ? c_val[2*j+1] : c_val[2*j];
                    n_idx[j] = b_win[j] ? c_idx[2*j+1] : c_idx[2*j];
                    n_tie[j] = (b_win[j] ? c_tie[2*j+1] : c_tie[2*j]) |
                               (c_vld[2*j] & c_vld[2*j+1] & (c_val[2*j] == c_val[2*j+1]));
                end
            end

            if (l < LEVELS) begin : g_reg
                always_ff @(posedge clk) begin
                    vld <= n_vld;
                    val <= n_val;
                    idx <= n_idx;
                    tie <= n_tie;
                end
            end else begin : g_root
                assign vld = n_vld;
                assign val = n_val;
                assign idx = n_idx;
                assign tie = n_tie;
            end
        end
    end

    logic [LEVELS-1:0] v_pipe;
    logic              root_load;

    // Valid that accompanies the data entering the output rank.
    if (LEVELS == 1) begin : g_load_direct
        assign root_load = in_valid;
    end else begin : g_load_chain
        assign root_load = v_pipe[LEVELS-2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
        end else begin
            v_pipe[0] <= in_valid;
            for (int i = 1; i < LEVELS; i++) v_pipe[i] <= v_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_index <= '0;
            out_value <= '0;
            out_tie   <= 1'b0;
        end else if (root_load && g_lvl[LEVELS].vld[0]) begin
            out_index <= g_lvl[LEVELS].idx[0];
            out_value <= g_lvl[LEVELS].val[0];
            out_tie   <= g_lvl[LEVELS].tie[0];
        end
    end

    assign out_valid = v_pipe[LEVELS-1];

endmodule

// File: tb/tb_argmax_pipe.sv
// Directed table plus corner sequences and gapped random regression for argmax_pipe.
module tb_argmax_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=10, W=5
    logic        v10 = 1'b0;
    logic [49:0] s10 = '0;
    logic        ov10, ot10;
    logic [3:0]  oi10;
    logic [4:0]  oval10;
    // N=10, W=8, signed and unsigned instances share stimulus
    logic        v8 = 1'b0;
    logic [79:0] s8 = '0;
    logic        ovs, ots, ovu, otu;
    logic [3:0]  ois, oiu;
    logic [7:0]  ovals, ovalu;
    // N=16, W=5
    logic        v16 = 1'b0;
    logic [79:0] s16 = '0;
    logic        ov16, ot16;
    logic [3:0]  oi16;
    logic [4:0]  oval16;
    // N=3, W=5
    logic        v3 = 1'b0;
    logic [14:0] s3 = '0;
    logic        ov3, ot3;
    logic [1:0]  oi3;
    logic [4:0]  oval3;
    // N=2, W=5
    logic        v2 = 1'b0;
    logic [9:0]  s2 = '0;
    logic        ov2, ot2;
    logic [0:0]  oi2;
    logic [4:0]  oval2;

    argmax_pipe #(.N_CLASSES(10), .W(5), .SIGNED(1'b0)) dut10 (
        .clk(clk), .rst(rst), .in_valid(v10), .in_scores(s10),
        .out_valid(ov10), .out_index(oi10), .out_value(oval10), .out_tie(ot10));
    argmax_pipe #(.N_CLASSES(10), .W(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(v8), .in_scores(s8),
        .out_valid(ovs), .out_index(ois), .out_value(ovals), .out_tie(ots));
    argmax_pipe #(.N_CLASSES(10), .W(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(v8), .in_scores(s8),
        .out_valid(ovu), .out_index(oiu), .out_value(ovalu), .out_tie(otu));
    argmax_pipe #(.N_CLASSES(16), .W(5), .SIGNED(1'b0)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_scores(s16),
        .out_valid(ov16), .out_index(oi16), .out_value(oval16), .out_tie(ot16));
    argmax_pipe #(.N_CLASSES(3), .W(5), .SIGNED(1'b0)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_scores(s3),
        .out_valid(ov3), .out_index(oi3), .out_value(oval3), .out_tie(ot3));
    argmax_pipe #(.N_CLASSES(2), .W(5), .SIGNED(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_scores(s2),
        .out_valid(ov2), .out_index(oi2), .out_value(oval2), .out_tie(ot2));

    typedef int arr10_t [10];
    typedef int arr16_t [16];
    typedef struct { logic [49:0] sc; int idx; int val; int tie; } vec_t;
    typedef struct { int due; int idx; int val; int tie; } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tab[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [49:0] p10(input arr10_t v);
        logic [49:0] r = '0;
        for (int k = 0; k < 10; k++) r[k*5 +: 5] = 5'(v[k]);
        return r;
    endfunction

    function automatic logic [79:0] p10w8(input arr10_t v);
        logic [79:0] r = '0;
        for (int k = 0; k < 10; k++) r[k*8 +: 8] = 8'(v[k]);
        return r;
    endfunction

    task automatic add10(input arr10_t v, input int idx, input int val, input int tie);
        vec_t e;
        e.sc = p10(v); e.idx = idx; e.val = val; e.tie = tie;
        tab.push_back(e);
    endtask

    // Linear-scan reference: first strict maximum, count of equal maxima.
    task automatic ref_max(input int n, input arr16_t sc, output int idx, output int val, output int tie);
        int cnt = 1;
        idx = 0; val = sc[0];
        for (int k = 1; k < n; k++) begin
            if (sc[k] > val) begin val = sc[k]; idx = k; cnt = 1; end
            else if (sc[k] == val) cnt++;
        end
        tie = (cnt >= 2) ? 1 : 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arr10_t tv;

        tv = '{1,2,3,4,5,6,7,8,9,10};          add10(tv, 9, 10, 0);
        tv = '{1,2,3,4,5,14,7,8,9,10};         add10(tv, 5, 14, 0);
        tv = '{1,13,3,4,5,6,7,8,9,0};          add10(tv, 1, 13, 0);
        tv = '{0,0,0,20,0,0,0,20,0,0};         add10(tv, 3, 20, 1);
        tv = '{0,0,0,0,0,0,0,0,0,0};           add10(tv, 0, 0, 1);
        tv = '{31,30,30,30,30,30,30,30,30,30}; add10(tv, 0, 31, 0);
        tv = '{0,0,0,0,0,0,0,0,17,17};         add10(tv, 8, 17, 1);
        tv = '{2,2,2,2,2,2,2,2,9,2};           add10(tv, 8, 9, 0);
        tv = '{7,7,1,1,1,1,1,1,1,8};           add10(tv, 9, 8, 0);
        tv = '{30,1,1,1,31,1,1,1,1,31};        add10(tv, 4, 31, 1);

        repeat (3) @(negedge clk);
        chk("rst_valid", ov10, 0);
        chk("rst_index", oi10, 0);
        chk("rst_value", oval10, 0);
        chk("rst_tie",   ot10, 0);
        rst = 1'b0;

        // Table: one vector at a time, latency checked exactly.
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            v10 = 1'b1; s10 = tab[i].sc;
            for (int c = 1; c < 4; c++) begin
                @(negedge clk);
                if (c == 1) begin v10 = 1'b0; s10 = 50'({$urandom, $urandom}); end
                chk($sformatf("tbl%0d_early_valid", i), ov10, 0);
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), ov10, 1);
            chk($sformatf("tbl%0d_index", i), oi10, tab[i].idx);
            chk($sformatf("tbl%0d_value", i), oval10, tab[i].val);
            chk($sformatf("tbl%0d_tie",   i), ot10, tab[i].tie);
        end

        // Back-to-back vectors, then hold with changing scores and no valid.
        @(negedge clk); v10 = 1'b1; s10 = tab[1].sc;
        @(negedge clk); s10 = tab[2].sc;
        @(negedge clk); v10 = 1'b0; s10 = tab[0].sc;
        @(negedge clk); chk("b2b_gap_valid", ov10, 0);
        @(negedge clk);
        chk("b2b0_valid", ov10, 1); chk("b2b0_index", oi10, 5);
        chk("b2b0_value", oval10, 14); chk("b2b0_tie", ot10, 0);
        @(negedge clk);
        chk("b2b1_valid", ov10, 1); chk("b2b1_index", oi10, 1);
        chk("b2b1_value", oval10, 13); chk("b2b1_tie", ot10, 0);
        @(negedge clk);
        chk("hold_valid", ov10, 0); chk("hold_index", oi10, 1);
        chk("hold_value", oval10, 13); chk("hold_tie", ot10, 0);

        // Reset two cycles after a vector discards it; next vector flows normally.
        @(negedge clk); v10 = 1'b1; s10 = tab[0].sc;
        @(negedge clk); v10 = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", ov10, 0); chk("rstmid_index", oi10, 0);
        chk("rstmid_value", oval10, 0); chk("rstmid_tie", ot10, 0);
        rst = 1'b0; v10 = 1'b1; s10 = tab[1].sc;
        @(negedge clk); v10 = 1'b0;
        chk("rstmid_discard_valid", ov10, 0); chk("rstmid_discard_value", oval10, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rstmid_early_valid", ov10, 0);
        end
        @(negedge clk);
        chk("post_rst_valid", ov10, 1); chk("post_rst_index", oi10, 5);
        chk("post_rst_value", oval10, 14); chk("post_rst_tie", ot10, 0);

        // Signed vs unsigned compare on identical vectors.
        begin
            arr10_t sv [3];
            int     e_s [3][3];
            int     e_u [3][3];
            sv[0] = '{'hFB,'hFB,'hFB,'hFB,'hFB,'hFB,'hFF,'hFB,'hFB,'hFB};
            sv[1] = '{'h01,'h01,'h01,'h01,'h01,'h01,'hFF,'h01,'h01,'h01};
            sv[2] = '{'h80,'h7F,0,0,0,0,0,0,0,0};
            e_s[0] = '{6, 'hFF, 0}; e_u[0] = '{6, 'hFF, 0};
            e_s[1] = '{0, 'h01, 1}; e_u[1] = '{6, 'hFF, 0};
            e_s[2] = '{1, 'h7F, 0}; e_u[2] = '{0, 'h80, 0};
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); v8 = 1'b1; s8 = p10w8(sv[i]);
                @(negedge clk); v8 = 1'b0;
                repeat (3) @(negedge clk);
                chk($sformatf("sgn%0d_valid", i), ovs, 1);
                chk($sformatf("sgn%0d_index", i), ois, e_s[i][0]);
                chk($sformatf("sgn%0d_value", i), ovals, e_s[i][1]);
                chk($sformatf("sgn%0d_tie",   i), ots, e_s[i][2]);
                chk($sformatf("uns%0d_valid", i), ovu, 1);
                chk($sformatf("uns%0d_index", i), oiu, e_u[i][0]);
                chk($sformatf("uns%0d_value", i), ovalu, e_u[i][1]);
                chk($sformatf("uns%0d_tie",   i), otu, e_u[i][2]);
            end
        end

        // Two-class instance: single-stage latency, tie, hold on invalid.
        @(negedge clk); v2 = 1'b1; s2 = {5'd7, 5'd3};
        @(negedge clk);
        chk("n2a_valid", ov2, 1); chk("n2a_index", oi2, 1);
        chk("n2a_value", oval2, 7); chk("n2a_tie", ot2, 0);
        s2 = {5'd7, 5'd7};
        @(negedge clk);
        chk("n2b_valid", ov2, 1); chk("n2b_index", oi2, 0);
        chk("n2b_value", oval2, 7); chk("n2b_tie", ot2, 1);
        v2 = 1'b0; s2 = {5'd31, 5'd0};
        @(negedge clk);
        chk("n2c_valid", ov2, 0); chk("n2c_index", oi2, 0);
        chk("n2c_value", oval2, 7); chk("n2c_tie", ot2, 1);

        // Gapped random regression, N=16 and N=3, against the linear-scan model.
        fork
            begin
                exp_t   q[$];
                exp_t   e;
                arr16_t sc;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (q.size() > 0 && q[0].due == i) begin
                        e = q.pop_front();
                        chk("r16_valid", ov16, 1);
                        chk("r16_index", oi16, e.idx);
                        chk("r16_value", oval16, e.val);
                        chk("r16_tie",   ot16, e.tie);
                    end else begin
                        chk("r16_bubble", ov16, 0);
                    end
                    if (i < 290 && $urandom_range(0, 3) != 0) begin
                        for (int k = 0; k < 16; k++) begin
                            sc[k] = $urandom_range(0, 7);
                            s16[k*5 +: 5] = 5'(sc[k]);
                        end
                        ref_max(16, sc, e.idx, e.val, e.tie);
                        e.due = i + 4;
                        q.push_back(e);
                        v16 = 1'b1;
                    end else begin
                        v16 = 1'b0;
                    end
                end
                chk("r16_drain", q.size(), 0);
            end
            begin
                exp_t   q[$];
                exp_t   e;
                arr16_t sc;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (q.size() > 0 && q[0].due == i) begin
                        e = q.pop_front();
                        chk("r3_valid", ov3, 1);
                        chk("r3_index", oi3, e.idx);
                        chk("r3_value", oval3, e.val);
                        chk("r3_tie",   ot3, e.tie);
                    end else begin
                        chk("r3_bubble", ov3, 0);
                    end
                    if (i < 290 && $urandom_range(0, 2) != 0) begin
                        for (int k = 0; k < 16; k++) sc[k] = 0;
                        for (int k = 0; k < 3; k++) begin
                            sc[k] = $urandom_range(0, 3);
                            s3[k*5 +: 5] = 5'(sc[k]);
                        end
                        ref_max(3, sc, e.idx, e.val, e.tie);
                        e.due = i + 2;
                        q.push_back(e);
                        v3 = 1'b1;
                    end else begin
                        v3 = 1'b0;
                    end
                end
                chk("r3_drain", q.size(), 0);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
